fetch_wf_arbiter: RTL and testbench

//  Upstream of the fetch controller. Tracks every dispatched wavefront and its PC and

---
 rtl/fetch_wf_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_fetch_wf_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_wf_arbiter.sv
// Round-robin fetch arbiter over NUM_WF wavefront slots with per-slot PC and credits; request registered, held until ack.
// Optional FETCH_HALT_EN adds wf_halt_mask; halted slots are never granted.
module fetch_wf_arbiter #(
  parameter int NUM_WF  = 40,
  parameter int WFID_W  = 6,
  parameter int CREDITS = 4,
  parameter int PC_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WF_dispatch_i,
  input  logic [WFID_W-1:0] wf_dispatch_wfid,
  input  logic [PC_W-1:0]   wf_dispatch_pc,
  input  logic              fetch_ack,
  input  logic              buff_slot_free,
  input  logic [WFID_W-1:0] buff_slot_free_wfid,
  input  logic              pc_redirect_valid,
  input  logic [WFID_W-1:0] pc_redirect_wfid,
  input  logic [PC_W-1:0]   pc_redirect_pc,
  input  logic              wf_done,
  input  logic [WFID_W-1:0] wf_done_wfid,
`ifdef FETCH_HALT_EN
  input  logic [NUM_WF-1:0] wf_halt_mask,
`endif
  output logic              fetch_valid,
  output logic [WFID_W-1:0] fetch_wfid,
  output logic [PC_W-1:0]   fetch_pc,
  output logic              credit_err
);

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  localparam logic [2:0]      LP_CREDITS = 3'(CREDITS);
  localparam logic [WFID_W:0] LP_NUM     = (WFID_W+1)'(NUM_WF);

  state_t            r_state, w_state_nxt;
  logic              r_fetch_valid, w_fetch_valid_nxt;
  logic [WFID_W-1:0] r_fetch_wfid, w_fetch_wfid_nxt;
  logic [PC_W-1:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic [WFID_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic              r_credit_err;

  logic [NUM_WF-1:0] w_elig;
  logic [NUM_WF-1:0] w_err_set;
  logic [NUM_WF-1:0] w_halt;
  logic [PC_W-1:0]   w_pc_next [NUM_WF];
  logic              w_found;
  logic [WFID_W-1:0] w_grant;
  logic [WFID_W:0]   w_idx;
  logic              w_cancel;

`ifdef FETCH_HALT_EN
  assign w_halt = wf_halt_mask;
`else
  assign w_halt = '0;
`endif

  for (genvar g = 0; g < NUM_WF; g++) begin : g_slot
    localparam logic [WFID_W-1:0] LP_ID = WFID_W'(g);

    logic            r_active, w_active_n;
    logic [2:0]      r_credit, w_credit_n;
    logic [PC_W-1:0] r_pc, w_pc_n;
    logic            w_disp_hit, w_free_hit, w_redir_hit, w_done_hit, w_ack_hit;

    // Out-of-range ids never match any slot, so they fall through untouched.
    assign w_disp_hit  = WF_dispatch_i && (wf_dispatch_wfid == LP_ID);
    assign w_free_hit  = buff_slot_free && (buff_slot_free_wfid == LP_ID);
    assign w_redir_hit = pc_redirect_valid && (pc_redirect_wfid == LP_ID);
    assign w_done_hit  = wf_done && (wf_done_wfid == LP_ID);
    assign w_ack_hit   = (r_state == S_PRESENT) && fetch_ack && (r_fetch_wfid == LP_ID);

    always_comb begin
      w_active_n = r_active;
      w_credit_n = r_credit;
      w_pc_n     = r_pc;
      if (w_ack_hit)
        w_pc_n = r_pc + PC_W'(4);
      if (w_redir_hit && r_active)
        w_pc_n = pc_redirect_pc;
      if (w_ack_hit && !w_free_hit)
        w_credit_n = r_credit - 3'd1;
      else if (w_free_hit && !w_ack_hit && r_active && (r_credit != LP_CREDITS))
        w_credit_n = r_credit + 3'd1;
      if (w_done_hit && r_active)
        w_active_n = 1'b0;
      if (w_disp_hit) begin
        w_active_n = 1'b1;
        w_credit_n = LP_CREDITS;
        w_pc_n     = wf_dispatch_pc;
      end
    end

    assign w_err_set[g] = w_free_hit && !w_ack_hit && (r_credit == LP_CREDITS);
    // Eligibility looks at this cycle's updates so a grant never carries a stale PC.
    assign w_elig[g]    = w_active_n && (w_credit_n != 3'd0) && !w_halt[g];
    assign w_pc_next[g] = w_pc_n;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_active <= 1'b0;
        r_credit <= LP_CREDITS;
        r_pc     <= '0;
      end else begin
        r_active <= w_active_n;
        r_credit <= w_credit_n;
        r_pc     <= w_pc_n;
      end
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_WF; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (WFID_W+1)'(k);
      if (w_idx >= LP_NUM)
        w_idx = w_idx - LP_NUM;
      if (!w_found && w_elig[w_idx[WFID_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[WFID_W-1:0];
      end
    end
  end

  assign w_cancel = (wf_done && (wf_done_wfid == r_fetch_wfid)) ||
                    (pc_redirect_valid && (pc_redirect_wfid == r_fetch_wfid)) ||
                    (WF_dispatch_i && (wf_dispatch_wfid == r_fetch_wfid));

  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_valid_nxt = r_fetch_valid;
    w_fetch_wfid_nxt  = r_fetch_wfid;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_rr_ptr_nxt      = r_rr_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt       = S_PRESENT;
          w_fetch_valid_nxt = 1'b1;
          w_fetch_wfid_nxt  = w_grant;
          w_fetch_pc_nxt    = w_pc_next[w_grant];
        end
      end
      S_PRESENT: begin
        if (fetch_ack) begin
          w_state_nxt       = S_IDLE;
          w_fetch_valid_nxt = 1'b0;
          w_rr_ptr_nxt      = (r_fetch_wfid == WFID_W'(NUM_WF-1)) ? '0 : r_fetch_wfid + WFID_W'(1);
        end else if (w_cancel) begin
          w_state_nxt       = S_IDLE;
          w_fetch_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_fetch_valid <= 1'b0;
      r_fetch_wfid  <= '0;
      r_fetch_pc    <= '0;
      r_rr_ptr      <= '0;
      r_credit_err  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_valid <= w_fetch_valid_nxt;
      r_fetch_wfid  <= w_fetch_wfid_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      if (|w_err_set)
        r_credit_err <= 1'b1;
    end
  end

  assign fetch_valid = r_fetch_valid;
  assign fetch_wfid  = r_fetch_wfid;
  assign fetch_pc    = r_fetch_pc;
  assign credit_err  = r_credit_err;

endmodule

// File: tb/tb_fetch_wf_arbiter.sv
// Directed bench for fetch_wf_arbiter: credits, round-robin wrap, cancel, redirect, sticky credit error.
module tb_fetch_wf_arbiter;
  localparam int NUM_WF = 40;
  localparam int WFID_W = 6;
  localparam int PC_W   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              WF_dispatch_i;
  logic [WFID_W-1:0] wf_dispatch_wfid;
  logic [PC_W-1:0]   wf_dispatch_pc;
  logic              fetch_ack;
  logic              buff_slot_free;
  logic [WFID_W-1:0] buff_slot_free_wfid;
  logic              pc_redirect_valid;
  logic [WFID_W-1:0] pc_redirect_wfid;
  logic [PC_W-1:0]   pc_redirect_pc;
  logic              wf_done;
  logic [WFID_W-1:0] wf_done_wfid;
`ifdef FETCH_HALT_EN
  logic [NUM_WF-1:0] wf_halt_mask;
`endif
  logic              fetch_valid;
  logic [WFID_W-1:0] fetch_wfid;
  logic [PC_W-1:0]   fetch_pc;
  logic              credit_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_wf_arbiter #(.NUM_WF(NUM_WF), .WFID_W(WFID_W), .CREDITS(4), .PC_W(PC_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .WF_dispatch_i       (WF_dispatch_i),
    .wf_dispatch_wfid    (wf_dispatch_wfid),
    .wf_dispatch_pc      (wf_dispatch_pc),
    .fetch_ack           (fetch_ack),
    .buff_slot_free      (buff_slot_free),
    .buff_slot_free_wfid (buff_slot_free_wfid),
    .pc_redirect_valid   (pc_redirect_valid),
    .pc_redirect_wfid    (pc_redirect_wfid),
    .pc_redirect_pc      (pc_redirect_pc),
    .wf_done             (wf_done),
    .wf_done_wfid        (wf_done_wfid),
`ifdef FETCH_HALT_EN
    .wf_halt_mask        (wf_halt_mask),
`endif
    .fetch_valid         (fetch_valid),
    .fetch_wfid          (fetch_wfid),
    .fetch_pc            (fetch_pc),
    .credit_err          (credit_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_valid", 64'(fetch_valid), 64'd0);
    check("rst_wfid", 64'(fetch_wfid), 64'd0);
    check("rst_pc", 64'(fetch_pc), 64'd0);
    check("rst_err", 64'(credit_err), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_no_req", 64'(fetch_valid), 64'd0);
  endtask

  task automatic expect_req(input string tag, input int wfid, input logic [PC_W-1:0] pc);
    int n = 0;
    while (fetch_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 64'(fetch_valid), 64'd1);
    check({tag, "_wfid"}, 64'(fetch_wfid), 64'(wfid));
    check({tag, "_pc"}, 64'(fetch_pc), 64'(pc));
  endtask

  task automatic do_ack();
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    check("ack_drop", 64'(fetch_valid), 64'd0);
  endtask

  task automatic dispatch(input int wfid, input logic [PC_W-1:0] pc);
    WF_dispatch_i    = 1'b1;
    wf_dispatch_wfid = WFID_W'(wfid);
    wf_dispatch_pc   = pc;
    tick();
    WF_dispatch_i    = 1'b0;
  endtask

  task automatic slot_free(input int wfid);
    buff_slot_free      = 1'b1;
    buff_slot_free_wfid = WFID_W'(wfid);
    tick();
    buff_slot_free      = 1'b0;
  endtask

  initial begin
    int   order [5] = '{39, 0, 3, 39, 0};
    logic [PC_W-1:0] pcs [5] = '{32'h390, 32'h1000, 32'h300, 32'h394, 32'h1004};

    WF_dispatch_i = 1'b0; wf_dispatch_wfid = '0; wf_dispatch_pc = '0;
    fetch_ack = 1'b0; buff_slot_free = 1'b0; buff_slot_free_wfid = '0;
    pc_redirect_valid = 1'b0; pc_redirect_wfid = '0; pc_redirect_pc = '0;
    wf_done = 1'b0; wf_done_wfid = '0;
`ifdef FETCH_HALT_EN
    wf_halt_mask = '0;
`endif
    do_reset();

    // Credits run out after four acked fetches, one freed slot releases one more.
    dispatch(5, 32'h100);
    for (int i = 0; i < 4; i++) begin
      expect_req($sformatf("cred%0d", i), 5, 32'h100 + 32'(4 * i));
      do_ack();
    end
    repeat (5) tick();
    check("stall_no_credit", 64'(fetch_valid), 64'd0);
    slot_free(5);
    expect_req("refill", 5, 32'h110);
    do_ack();
    slot_free(5);
    expect_req("refill2", 5, 32'h114);
    do_reset();

    // Round-robin with wrap 39 -> 0 while 39 sits unacked.
    dispatch(39, 32'h390);
    dispatch(0, 32'h1000);
    dispatch(3, 32'h300);
    check("hold_wfid", 64'(fetch_wfid), 64'd39);
    for (int i = 0; i < 5; i++) begin
      expect_req($sformatf("rr%0d", i), order[i], pcs[i]);
      do_ack();
    end

    // Redirect cancels the presented request, then ack+redirect takes the redirect PC.
    expect_req("pre_cancel", 3, 32'h304);
    pc_redirect_valid = 1'b1; pc_redirect_wfid = 6'd3; pc_redirect_pc = 32'h200;
    tick();
    pc_redirect_valid = 1'b0;
    check("cancel_drop", 64'(fetch_valid), 64'd0);
    expect_req("after_redir", 3, 32'h200);
    fetch_ack = 1'b1;
    pc_redirect_valid = 1'b1; pc_redirect_wfid = 6'd3; pc_redirect_pc = 32'h500;
    tick();
    fetch_ack = 1'b0;
    pc_redirect_valid = 1'b0;
    check("ack_redir_drop", 64'(fetch_valid), 64'd0);
    expect_req("g39", 39, 32'h398);
    do_ack();
    expect_req("g0", 0, 32'h1008);
    do_ack();
    expect_req("g3_redir", 3, 32'h500);
    do_ack();

    // Credit error: out-of-range id ignored, full inactive slot flags, flag is sticky.
    expect_req("s5_39", 39, 32'h39C);
    slot_free(50);
    check("oob_no_err", 64'(credit_err), 64'd0);
    check("oob_hold", 64'(fetch_valid), 64'd1);
    slot_free(7);
    check("err_set", 64'(credit_err), 64'd1);
    wf_done = 1'b1; wf_done_wfid = 6'd39;
    tick();
    wf_done = 1'b0;
    check("done_cancel", 64'(fetch_valid), 64'd0);
    expect_req("after_done", 0, 32'h100C);
    check("err_sticky", 64'(credit_err), 64'd1);
    do_ack();

`ifdef FETCH_HALT_EN
    do_reset();
    wf_halt_mask = '0;
    wf_halt_mask[5] = 1'b1;
    dispatch(5, 32'h100);
    repeat (6) tick();
    check("halt_block", 64'(fetch_valid), 64'd0);
    wf_halt_mask = '0;
    expect_req("halt_resume", 5, 32'h100);
    do_ack();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end
endmodule
